traffic_generator_burst_scheduler: RTL and testbench
====================================================

Name: traffic_generator_burst_scheduler

Overview:
Sequences the GMII traffic generator's frame engine according to the burst profile registers: interframe gap, interburst gap, frames per burst and total frames. Sits between the CPU register block and the frame-output datapath, in the `clk` domain. Issues one frame request at a time over a valid/ready handshake and waits for frame completion. Then times the following gap and reports progress counters back to the registers.

Parameters:
CNT_WIDTH, 32, width of frame/burst count config and status counters
GAP_WIDTH, 32, width of gap config values and internal gap counter

Ports:
clk  in  1  core clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
run  in  1  level enable (control_reg[0])
interframe_gap  in  GAP_WIDTH  idle cycles between frames within a burst
interburst_gap  in  GAP_WIDTH  idle cycles after the last frame of a burst
frames_per_burst  in  CNT_WIDTH  frames per burst; 0 = single unbounded burst
total_frames  in  CNT_WIDTH  frames per run; 0 = continuous
frame_req_valid  out  1  request to frame engine to start one frame
frame_req_ready  in  1  frame engine accepts request
frame_done  in  1  one-cycle pulse, frame engine finished last byte
busy  out  1  high in any state except IDLE and DONE
done  out  1  high in DONE
frames_sent  out  CNT_WIDTH  frames completed this run
bursts_sent  out  CNT_WIDTH  bursts completed this run
done_err  out  1  sticky: frame_done seen outside TX
sec  in  48  PTP seconds (used only with the optional feature)
nsec  in  30  PTP nanoseconds (used only with the optional feature)
tx_sec  out  48  timestamp of last accepted request (optional feature)
tx_nsec  out  30  timestamp of last accepted request (optional feature)

Behaviour:
- Reset: state=IDLE. All outputs 0: frame_req_valid, busy, done, frames_sent, bursts_sent, done_err, tx_sec, tx_nsec. Reset mid-operation aborts immediately; no frame_done is awaited.
- All outputs are registered.
- States: IDLE, REQ, TX, GAP, DONE.
- IDLE, run=1:
  - Latch all four config inputs into shadow registers.
  - Clear frames_sent, bursts_sent, done_err and the in-burst counter.
  - Go to REQ; frame_req_valid is 1 the next cycle.
  - Config changes mid-run are ignored until the next start.
- REQ:
  - frame_req_valid=1.
  - Handshake on frame_req_valid & frame_req_ready: go to TX; valid drops the next cycle.
  - run=0 before acceptance: go to IDLE; valid drops; no frame is counted.
- TX: wait for frame_done. On frame_done:
  - frames_sent+1 and in-burst+1.
  - If total!=0 and frames_sent+1==total: DONE.
  - Else if run=0: IDLE. frame_done and run fall in the same cycle: the frame is counted, then IDLE.
  - Else if fpb!=0 and in-burst+1==fpb: bursts_sent+1, in-burst cleared, gap value G=interburst_gap.
  - Else G=interframe_gap.
  - G==0: go to REQ.
  - G>0: go to GAP with gap counter=G-1.
- GAP:
  - Exactly G cycles in GAP; frame_req_valid rises G+1 cycles after the frame_done cycle.
  - Counter==0: go to REQ; otherwise decrement.
  - run=0: IDLE next cycle.
- DONE:
  - When the last frame also completes a burst, bursts_sent also increments.
  - Hold until run=0, then IDLE. A new run requires a run 0→1 cycle.
- frame_done while not in TX: ignored for counting; sets done_err.
- Counters wrap modulo 2^CNT_WIDTH.

Optional Feature:
TRAFFIC_SCHED_TIMESTAMP_EN
- Defined: on each accepted request, tx_sec<=sec and tx_nsec<=nsec; values are held until the next accept or reset.
- Undefined: tx_sec and tx_nsec tied to 0, no timestamp registers built; sec and nsec unused.

Test Plan:
- Basic handshake: fpb=0, total=3, ifg=4, ready tied 1, frame_done 10 cycles after accept → 3 requests spaced by 4 idle GAP cycles; frames_sent=3, bursts_sent=0, done=1 and held until run=0.
- Bursts: fpb=2, total=6, ifg=2, ibg=20 → gaps 2,20,2,20,2; bursts_sent=3; done after the 6th frame_done.
- Zero gap plus backpressure: ifg=0; ready low 5 cycles each request → valid held 5 cycles, rises the cycle after frame_done; exactly one accept per frame.
- Stop mid-run: total=0; drop run in REQ → IDLE, frames_sent unchanged. Drop run during TX → frame counted on frame_done, then IDLE.
- Errors and reset: frame_done pulsed in IDLE → done_err=1, counts 0. rst asserted in GAP → all outputs 0 the next cycle.
- With TRAFFIC_SCHED_TIMESTAMP_EN: sec=5, nsec=1000 at the accept cycle → tx_sec=5, tx_nsec=1000 the next cycle. Without the macro → both remain 0.

Source files
------------

// File: rtl/traffic_generator_burst_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_generator_burst_scheduler_if
//  Purpose  : Frame-request handshake between the burst scheduler and the
//             frame engine.
//  Signals  : frame_req_valid  scheduler -> engine, request one frame
//             frame_req_ready  engine -> scheduler, request accepted
//             frame_done       engine -> scheduler, one-cycle end-of-frame
//  Modports : master (scheduler side), slave (frame engine side)
//  Revision : 1.0  initial release
// ============================================================================
interface traffic_generator_burst_scheduler_if;
  logic frame_req_valid;
  logic frame_req_ready;
  logic frame_done;

  modport master (
    output frame_req_valid,
    input  frame_req_ready,
    input  frame_done
  );

  modport slave (
    input  frame_req_valid,
    output frame_req_ready,
    output frame_done
  );
endinterface
`default_nettype wire

// File: rtl/traffic_generator_burst_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_generator_burst_scheduler
//  Purpose  : Paces the traffic generator's frame engine from the burst
//             profile (interframe gap, interburst gap, frames per burst,
//             total frames). Issues one frame request at a time, waits for
//             frame completion, times the following gap and reports progress.
//  Ports    : clk, rst            clock, synchronous active-high reset
//             run                 level enable
//             interframe_gap      idle cycles between frames in a burst
//             interburst_gap      idle cycles after the last frame of a burst
//             frames_per_burst    0 = single unbounded burst
//             total_frames        0 = continuous
//             req_if (master)     frame_req_valid / frame_req_ready / frame_done
//             busy, done          status (busy: REQ/TX/GAP, done: DONE)
//             frames_sent         frames completed this run
//             bursts_sent         bursts completed this run
//             done_err            sticky, frame_done seen outside TX
//             sec, nsec           PTP time (timestamp option only)
//             tx_sec, tx_nsec     time of the last accepted request
//  Options  : TRAFFIC_SCHED_TIMESTAMP_EN builds the request timestamp
//             registers; otherwise tx_sec/tx_nsec are tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module traffic_generator_burst_scheduler #(
  parameter int CNT_WIDTH = 32,
  parameter int GAP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [GAP_WIDTH-1:0] interframe_gap,
  input  logic [GAP_WIDTH-1:0] interburst_gap,
  input  logic [CNT_WIDTH-1:0] frames_per_burst,
  input  logic [CNT_WIDTH-1:0] total_frames,
  traffic_generator_burst_scheduler_if.master req_if,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] frames_sent,
  output logic [CNT_WIDTH-1:0] bursts_sent,
  output logic                 done_err,
  input  logic [47:0]          sec,
  input  logic [29:0]          nsec,
  output logic [47:0]          tx_sec,
  output logic [29:0]          tx_nsec
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    TX   = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Shadow copies of the profile, frozen at start so mid-run writes are ignored
  logic [GAP_WIDTH-1:0] ifg_q, ifg_d;
  logic [GAP_WIDTH-1:0] ibg_q, ibg_d;
  logic [CNT_WIDTH-1:0] fpb_q, fpb_d;
  logic [CNT_WIDTH-1:0] total_q, total_d;

  logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_WIDTH-1:0] frames_q, frames_d;
  logic [CNT_WIDTH-1:0] bursts_q, bursts_d;
  logic [CNT_WIDTH-1:0] in_burst_q, in_burst_d;

  logic valid_q, valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic                 accept;
  logic [CNT_WIDTH-1:0] frames_inc;
  logic [CNT_WIDTH-1:0] in_burst_inc;
  logic                 last_frame;
  logic                 burst_end;
  logic [GAP_WIDTH-1:0] gap_sel;

  // valid_q is only ever high in REQ, so it alone qualifies the handshake
  assign accept       = valid_q & req_if.frame_req_ready;
  assign frames_inc   = frames_q + CNT_WIDTH'(1);
  assign in_burst_inc = in_burst_q + CNT_WIDTH'(1);
  assign last_frame   = (total_q != '0) && (frames_inc == total_q);
  assign burst_end    = (fpb_q != '0) && (in_burst_inc == fpb_q);
  assign gap_sel      = burst_end ? ibg_q : ifg_q;

  always_comb begin
    state_d    = state_q;
    ifg_d      = ifg_q;
    ibg_d      = ibg_q;
    fpb_d      = fpb_q;
    total_d    = total_q;
    gap_cnt_d  = gap_cnt_q;
    frames_d   = frames_q;
    bursts_d   = bursts_q;
    in_burst_d = in_burst_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (run) begin
          ifg_d      = interframe_gap;
          ibg_d      = interburst_gap;
          fpb_d      = frames_per_burst;
          total_d    = total_frames;
          frames_d   = '0;
          bursts_d   = '0;
          in_burst_d = '0;
          err_d      = 1'b0;
          state_d    = REQ;
        end
      end
      REQ: begin
        // An accept in the same cycle run falls still commits the frame
        if (accept) begin
          state_d = TX;
        end else if (!run) begin
          state_d = IDLE;
        end
      end
      TX: begin
        if (req_if.frame_done) begin
          frames_d   = frames_inc;
          in_burst_d = in_burst_inc;
          if (last_frame) begin
            if (burst_end) begin
              bursts_d   = bursts_q + CNT_WIDTH'(1);
              in_burst_d = '0;
            end
            state_d = DONE;
          end else if (!run) begin
            state_d = IDLE;
          end else begin
            if (burst_end) begin
              bursts_d   = bursts_q + CNT_WIDTH'(1);
              in_burst_d = '0;
            end
            // Counter is loaded with G-1 so GAP lasts exactly G cycles
            if (gap_sel == '0) begin
              state_d = REQ;
            end else begin
              gap_cnt_d = gap_sel - GAP_WIDTH'(1);
              state_d   = GAP;
            end
          end
        end
      end
      GAP: begin
        if (!run) begin
          state_d = IDLE;
        end else if (gap_cnt_q == '0) begin
          state_d = REQ;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end
      DONE: begin
        if (!run) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A completion outside TX is never counted, only flagged
    if (req_if.frame_done && (state_q != TX)) begin
      err_d = 1'b1;
    end

    // Status outputs are registered copies of the next state
    valid_d = (state_d == REQ);
    busy_d  = (state_d == REQ) || (state_d == TX) || (state_d == GAP);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ifg_q      <= '0;
      ibg_q      <= '0;
      fpb_q      <= '0;
      total_q    <= '0;
      gap_cnt_q  <= '0;
      frames_q   <= '0;
      bursts_q   <= '0;
      in_burst_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ifg_q      <= ifg_d;
      ibg_q      <= ibg_d;
      fpb_q      <= fpb_d;
      total_q    <= total_d;
      gap_cnt_q  <= gap_cnt_d;
      frames_q   <= frames_d;
      bursts_q   <= bursts_d;
      in_burst_q <= in_burst_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign req_if.frame_req_valid = valid_q;
  assign busy                   = busy_q;
  assign done                   = done_q;
  assign frames_sent            = frames_q;
  assign bursts_sent            = bursts_q;
  assign done_err               = err_q;

`ifdef TRAFFIC_SCHED_TIMESTAMP_EN
  logic [47:0] tx_sec_q, tx_sec_d;
  logic [29:0] tx_nsec_q, tx_nsec_d;

  always_comb begin
    tx_sec_d  = tx_sec_q;
    tx_nsec_d = tx_nsec_q;
    if (accept) begin
      tx_sec_d  = sec;
      tx_nsec_d = nsec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sec_q  <= '0;
      tx_nsec_q <= '0;
    end else begin
      tx_sec_q  <= tx_sec_d;
      tx_nsec_q <= tx_nsec_d;
    end
  end

  assign tx_sec  = tx_sec_q;
  assign tx_nsec = tx_nsec_q;
`else
  logic unused_ts;
  assign unused_ts = ^{sec, nsec};
  assign tx_sec    = '0;
  assign tx_nsec   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_traffic_generator_burst_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_generator_burst_scheduler
//  Purpose  : Self-checking bench for traffic_generator_burst_scheduler.
//             Expected gaps, frame and burst counts come from the burst
//             profile arithmetic (gap after frame n, n/fpb bursts).
//  Revision : 1.0  initial release
// ============================================================================
module tb_traffic_generator_burst_scheduler;
  localparam int CW = 32;
  localparam int GW = 32;
`ifdef TRAFFIC_SCHED_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [GW-1:0] interframe_gap;
  logic [GW-1:0] interburst_gap;
  logic [CW-1:0] frames_per_burst;
  logic [CW-1:0] total_frames;
  logic          busy;
  logic          done;
  logic [CW-1:0] frames_sent;
  logic [CW-1:0] bursts_sent;
  logic          done_err;
  logic [47:0]   sec;
  logic [29:0]   nsec;
  logic [47:0]   tx_sec;
  logic [29:0]   tx_nsec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_generator_burst_scheduler_if bus ();

  traffic_generator_burst_scheduler #(
    .CNT_WIDTH(CW),
    .GAP_WIDTH(GW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .run             (run),
    .interframe_gap  (interframe_gap),
    .interburst_gap  (interburst_gap),
    .frames_per_burst(frames_per_burst),
    .total_frames    (total_frames),
    .req_if          (bus),
    .busy            (busy),
    .done            (done),
    .frames_sent     (frames_sent),
    .bursts_sent     (bursts_sent),
    .done_err        (done_err),
    .sec             (sec),
    .nsec            (nsec),
    .tx_sec          (tx_sec),
    .tx_nsec         (tx_nsec)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete run with the given profile (total must be non-zero).
  task automatic do_run(input int ifg, input int ibg, input int fpb, input int total,
                        input int rdy_lo, input int rdy_hi, input int dly_lo, input int dly_hi);
    int c;
    int g;
    logic [47:0] s;
    logic [29:0] ns;
    interframe_gap   = GW'(ifg);
    interburst_gap   = GW'(ibg);
    frames_per_burst = CW'(fpb);
    total_frames     = CW'(total);
    run = 1'b1;
    step();
    // Profile writes after start must have no effect on this run
    interframe_gap   = GW'($urandom_range(0, 9));
    interburst_gap   = GW'($urandom_range(0, 9));
    frames_per_burst = CW'($urandom_range(0, 3));
    total_frames     = CW'($urandom_range(1, 3));
    chk("start_busy", {63'd0, busy}, 64'd1);
    chk("start_frames", {32'd0, frames_sent}, 64'd0);
    for (int n = 1; n <= total; n++) begin
      c = $urandom_range(rdy_lo, rdy_hi);
      for (int i = 0; i < c; i++) begin
        chk("req_hold", {63'd0, bus.frame_req_valid}, 64'd1);
        step();
      end
      chk("req_valid", {63'd0, bus.frame_req_valid}, 64'd1);
      if (n == 1) begin
        s  = 48'd5;
        ns = 30'd1000;
      end else begin
        s  = {16'd0, 32'($urandom)};
        ns = 30'($urandom);
      end
      sec  = s;
      nsec = ns;
      bus.frame_req_ready = 1'b1;
      step();
      bus.frame_req_ready = 1'b0;
      sec  = '0;
      nsec = '0;
      chk("accept_drop", {63'd0, bus.frame_req_valid}, 64'd0);
      chk("tx_sec", {16'd0, tx_sec}, TS_EN ? {16'd0, s} : 64'd0);
      chk("tx_nsec", {34'd0, tx_nsec}, TS_EN ? {34'd0, ns} : 64'd0);
      c = $urandom_range(dly_lo, dly_hi);
      for (int i = 0; i < c; i++) step();
      bus.frame_done = 1'b1;
      step();
      bus.frame_done = 1'b0;
      chk("frames_sent", {32'd0, frames_sent}, 64'(n));
      chk("bursts_sent", {32'd0, bursts_sent}, (fpb != 0) ? 64'(n / fpb) : 64'd0);
      if (n == total) begin
        chk("done_set", {63'd0, done}, 64'd1);
        chk("done_busy", {63'd0, busy}, 64'd0);
        chk("done_valid", {63'd0, bus.frame_req_valid}, 64'd0);
      end else begin
        g = ((fpb != 0) && (n % fpb == 0)) ? ibg : ifg;
        c = 0;
        while ((bus.frame_req_valid !== 1'b1) && (c < g + 8)) begin
          chk("gap_busy", {63'd0, busy}, 64'd1);
          step();
          c++;
        end
        chk("gap_len", 64'(c), 64'(g));
      end
    end
    chk("err_clean", {63'd0, done_err}, 64'd0);
    repeat (3) step();
    chk("done_hold", {63'd0, done}, 64'd1);
    chk("done_no_req", {63'd0, bus.frame_req_valid}, 64'd0);
    run = 1'b0;
    step();
    chk("done_clear", {63'd0, done}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    run = 1'b0;
    interframe_gap   = '0;
    interburst_gap   = '0;
    frames_per_burst = '0;
    total_frames     = '0;
    sec  = '0;
    nsec = '0;
    bus.frame_req_ready = 1'b0;
    bus.frame_done      = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_valid", {63'd0, bus.frame_req_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_frames", {32'd0, frames_sent}, 64'd0);
    chk("rst_bursts", {32'd0, bursts_sent}, 64'd0);
    chk("rst_err", {63'd0, done_err}, 64'd0);
    chk("rst_tx_sec", {16'd0, tx_sec}, 64'd0);

    // Basic handshake, bursts, zero gap with backpressure
    do_run(4, 0, 0, 3, 0, 0, 10, 10);
    do_run(2, 20, 2, 6, 0, 0, 3, 3);
    do_run(0, 0, 0, 3, 5, 5, 2, 2);

    // Randomised profiles
    for (int r = 0; r < 8; r++) begin
      do_run($urandom_range(0, 5), $urandom_range(0, 8), $urandom_range(0, 3),
             $urandom_range(1, 7), 0, 3, 1, 4);
    end

    // Stop in REQ: nothing counted
    interframe_gap   = '0;
    interburst_gap   = '0;
    frames_per_burst = '0;
    total_frames     = '0;
    run = 1'b1;
    step();
    chk("stop_req_valid", {63'd0, bus.frame_req_valid}, 64'd1);
    run = 1'b0;
    step();
    chk("stop_req_drop", {63'd0, bus.frame_req_valid}, 64'd0);
    chk("stop_req_busy", {63'd0, busy}, 64'd0);
    chk("stop_req_frames", {32'd0, frames_sent}, 64'd0);

    // Stop in TX: frame counted on completion, then idle
    run = 1'b1;
    step();
    bus.frame_req_ready = 1'b1;
    step();
    bus.frame_req_ready = 1'b0;
    repeat (2) step();
    bus.frame_done = 1'b1;
    step();
    bus.frame_done = 1'b0;
    chk("cont_frames", {32'd0, frames_sent}, 64'd1);
    chk("cont_req", {63'd0, bus.frame_req_valid}, 64'd1);
    bus.frame_req_ready = 1'b1;
    step();
    bus.frame_req_ready = 1'b0;
    run = 1'b0;
    repeat (2) step();
    chk("stop_tx_wait", {63'd0, busy}, 64'd1);
    bus.frame_done = 1'b1;
    step();
    bus.frame_done = 1'b0;
    chk("stop_tx_frames", {32'd0, frames_sent}, 64'd2);
    chk("stop_tx_busy", {63'd0, busy}, 64'd0);
    chk("stop_tx_done", {63'd0, done}, 64'd0);
    step();
    chk("stop_tx_idle", {63'd0, bus.frame_req_valid}, 64'd0);

    // frame_done in IDLE flags an error without counting
    bus.frame_done = 1'b1;
    step();
    bus.frame_done = 1'b0;
    chk("err_idle", {63'd0, done_err}, 64'd1);
    chk("err_idle_frames", {32'd0, frames_sent}, 64'd2);
    step();
    chk("err_sticky", {63'd0, done_err}, 64'd1);

    // Restart clears status; then reset in GAP
    interframe_gap   = GW'(10);
    interburst_gap   = GW'(10);
    frames_per_burst = CW'(1);
    total_frames     = '0;
    run = 1'b1;
    step();
    chk("restart_err", {63'd0, done_err}, 64'd0);
    chk("restart_frames", {32'd0, frames_sent}, 64'd0);
    sec  = 48'd77;
    nsec = 30'd123;
    bus.frame_req_ready = 1'b1;
    step();
    bus.frame_req_ready = 1'b0;
    repeat (2) step();
    bus.frame_done = 1'b1;
    step();
    bus.frame_done = 1'b0;
    chk("gap_bursts", {32'd0, bursts_sent}, 64'd1);
    step();
    chk("gap_in_gap", {63'd0, busy}, 64'd1);
    bus.frame_done = 1'b1;
    step();
    bus.frame_done = 1'b0;
    chk("err_gap", {63'd0, done_err}, 64'd1);
    chk("err_gap_frames", {32'd0, frames_sent}, 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run = 1'b0;
    chk("grst_valid", {63'd0, bus.frame_req_valid}, 64'd0);
    chk("grst_busy", {63'd0, busy}, 64'd0);
    chk("grst_done", {63'd0, done}, 64'd0);
    chk("grst_frames", {32'd0, frames_sent}, 64'd0);
    chk("grst_bursts", {32'd0, bursts_sent}, 64'd0);
    chk("grst_err", {63'd0, done_err}, 64'd0);
    chk("grst_tx_sec", {16'd0, tx_sec}, 64'd0);
    chk("grst_tx_nsec", {34'd0, tx_nsec}, 64'd0);
    step();
    chk("grst_stay_idle", {63'd0, busy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
